// File: rtl/xix4_phase_sequencer.sv
// xix4_phase_sequencer
//
// Sequences the DDCB/FDCB four-byte instruction group. It owns the XIX4/XIY4
// prefix flags, the 4-bit phase counter XPT and the latched fourth opcode
// byte. These feed the XIX4 phase decoder. A bus phase is stretched while
// memory is not ready.
//
// Ports
//   CLK, RESET                      clock, synchronous active-high reset
//   Set_XIX4, Set_XIY4              prefix seen: start an IX / IY sequence
//   Ld_Source, Dt_in[7:0]           capture the fourth opcode byte
//   PR_Reset_XPT                    decoder end-of-instruction strobe
//   P2_Reset_XIX4, P2_Reset_XIY4    decoder flag clears
//   P2_Set_CM1, M1_ack              set / clear the pending-M1 flag
//   PC_R1, PC_W1, mem_wait          middle bus phases and memory wait
//   XPT[3:0], notXPT[3:0]           current phase and its inverse
//   Source[7:0], notSource[7:0]     latched opcode byte and its inverse
//   not_enable                      active-low decoder enable
//   is_Y                            1 = IY sequence
//   CM1                             M1 fetch pending
//   stall                           phase held this cycle
//   seq_err                         sticky overrun error
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no instruction in flight, decoder disabled
// RUN   | XPT advances one phase per clock
// STALL | XPT held while memory wait stretches a read/write phase

module xix4_phase_sequencer (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       Set_XIX4,
    input  logic       Set_XIY4,
    input  logic       Ld_Source,
    input  logic [7:0] Dt_in,
    input  logic       PR_Reset_XPT,
    input  logic       P2_Reset_XIX4,
    input  logic       P2_Reset_XIY4,
    input  logic       P2_Set_CM1,
    input  logic       PC_R1,
    input  logic       PC_W1,
    input  logic       mem_wait,
    input  logic       M1_ack,
    output logic [3:0] XPT,
    output logic [3:0] notXPT,
    output logic [7:0] Source,
    output logic [7:0] notSource,
    output logic       not_enable,
    output logic       is_Y,
    output logic       CM1,
    output logic       stall,
    output logic       seq_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [3:0] LAST_PHASE = 4'd11;

    state_t state;
    logic   xix4;
    logic   xiy4;

    logic set_any;
    logic xix4_kept;
    logic xiy4_kept;
    logic flags_done;
    logic end_instr;
    logic run_stall;

    assign set_any    = Set_XIX4 | Set_XIY4;
    assign xix4_kept  = xix4 & ~P2_Reset_XIX4;
    assign xiy4_kept  = xiy4 & ~P2_Reset_XIY4;
    assign flags_done = ~xix4_kept & ~xiy4_kept;
    // Either the decoder's end strobe or both flags being cleared ends the
    // instruction; that also opens the window for a back-to-back Set_*.
    assign end_instr  = PR_Reset_XPT | flags_done;
    assign run_stall  = mem_wait & (PC_R1 | PC_W1);

    assign notXPT     = ~XPT;
    assign notSource  = ~Source;
    assign not_enable = (state == IDLE);
    assign is_Y       = xiy4;

    // The end of an instruction outranks a stall request, so stall is not
    // reported in a cycle that is about to return to phase 0.
    always_comb begin
        stall = 1'b0;
        case (state)
            RUN:     stall = run_stall & ~end_instr;
            STALL:   stall = mem_wait & ~flags_done;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            XPT     <= 4'd0;
            xix4    <= 1'b0;
            xiy4    <= 1'b0;
            Source  <= 8'd0;
            CM1     <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            if (Ld_Source)
                Source <= Dt_in;

            if (P2_Set_CM1)
                CM1 <= 1'b1;
            else if (M1_ack)
                CM1 <= 1'b0;

            case (state)
                IDLE: begin
                    if (set_any) begin
                        state <= RUN;
                        XPT   <= 4'd0;
                        // IY wins a tie; the other flag is always cleared
                        // so the two flags can never be set together.
                        xiy4  <= Set_XIY4;
                        xix4  <= Set_XIX4 & ~Set_XIY4;
                    end else begin
                        xix4 <= xix4_kept;
                        xiy4 <= xiy4_kept;
                    end
                end

                RUN: begin
                    if (end_instr) begin
                        XPT <= 4'd0;
                        if (set_any) begin
                            state <= RUN;
                            xiy4  <= Set_XIY4;
                            xix4  <= Set_XIX4 & ~Set_XIY4;
                        end else begin
                            state <= IDLE;
                            xix4  <= xix4_kept;
                            xiy4  <= xiy4_kept;
                        end
                    end else if (run_stall) begin
                        state <= STALL;
                        xix4  <= xix4_kept;
                        xiy4  <= xiy4_kept;
                    end else if (XPT == LAST_PHASE) begin
                        // Decoder never ended the instruction: abort it.
                        seq_err <= 1'b1;
                        XPT     <= 4'd0;
                        xix4    <= 1'b0;
                        xiy4    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        XPT  <= XPT + 4'd1;
                        xix4 <= xix4_kept;
                        xiy4 <= xiy4_kept;
                    end
                end

                STALL: begin
                    if (flags_done) begin
                        XPT   <= 4'd0;
                        xix4  <= 1'b0;
                        xiy4  <= 1'b0;
                        state <= IDLE;
                    end else if (mem_wait) begin
                        xix4 <= xix4_kept;
                        xiy4 <= xiy4_kept;
                    end else if (XPT == LAST_PHASE) begin
                        seq_err <= 1'b1;
                        XPT     <= 4'd0;
                        xix4    <= 1'b0;
                        xiy4    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        // Wait released: advance in the same cycle.
                        XPT   <= XPT + 4'd1;
                        xix4  <= xix4_kept;
                        xiy4  <= xiy4_kept;
                        state <= RUN;
                    end
                end

                default: begin
                    state <= IDLE;
                    XPT   <= 4'd0;
                    xix4  <= 1'b0;
                    xiy4  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xix4_phase_sequencer.sv
// tb_xix4_phase_sequencer
//
// Directed, table-driven bench for xix4_phase_sequencer. Each record holds
// one clock's inputs and the expected outputs: stall before the edge, the
// registered outputs after it. Expectations are hand-derived constants.

module tb_xix4_phase_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       Set_XIX4 = 1'b0;
    logic       Set_XIY4 = 1'b0;
    logic       Ld_Source = 1'b0;
    logic [7:0] Dt_in = 8'd0;
    logic       PR_Reset_XPT = 1'b0;
    logic       P2_Reset_XIX4 = 1'b0;
    logic       P2_Reset_XIY4 = 1'b0;
    logic       P2_Set_CM1 = 1'b0;
    logic       PC_R1 = 1'b0;
    logic       PC_W1 = 1'b0;
    logic       mem_wait = 1'b0;
    logic       M1_ack = 1'b0;
    logic [3:0] XPT;
    logic [3:0] notXPT;
    logic [7:0] Source;
    logic [7:0] notSource;
    logic       not_enable;
    logic       is_Y;
    logic       CM1;
    logic       stall;
    logic       seq_err;

    always #5 CLK = ~CLK;

    xix4_phase_sequencer dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .Set_XIX4      (Set_XIX4),
        .Set_XIY4      (Set_XIY4),
        .Ld_Source     (Ld_Source),
        .Dt_in         (Dt_in),
        .PR_Reset_XPT  (PR_Reset_XPT),
        .P2_Reset_XIX4 (P2_Reset_XIX4),
        .P2_Reset_XIY4 (P2_Reset_XIY4),
        .P2_Set_CM1    (P2_Set_CM1),
        .PC_R1         (PC_R1),
        .PC_W1         (PC_W1),
        .mem_wait      (mem_wait),
        .M1_ack        (M1_ack),
        .XPT           (XPT),
        .notXPT        (notXPT),
        .Source        (Source),
        .notSource     (notSource),
        .not_enable    (not_enable),
        .is_Y          (is_Y),
        .CM1           (CM1),
        .stall         (stall),
        .seq_err       (seq_err)
    );

    typedef struct packed {
        logic       rst;
        logic       sx;
        logic       sy;
        logic       ld;
        logic [7:0] dt;
        logic       pr;
        logic       p2x;
        logic       p2y;
        logic       scm1;
        logic       ack;
        logic       pcr;
        logic       pcw;
        logic       mw;
        logic       e_stall;
        logic [3:0] e_xpt;
        logic [7:0] e_src;
        logic       e_ne;
        logic       e_isy;
        logic       e_cm1;
        logic       e_err;
    } vec_t;

    vec_t vq[$];
    vec_t w;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t clr_in(input vec_t v);
        vec_t r;
        r      = v;
        r.rst  = 1'b0;
        r.sx   = 1'b0;
        r.sy   = 1'b0;
        r.ld   = 1'b0;
        r.dt   = 8'd0;
        r.pr   = 1'b0;
        r.p2x  = 1'b0;
        r.p2y  = 1'b0;
        r.scm1 = 1'b0;
        r.ack  = 1'b0;
        r.pcr  = 1'b0;
        r.pcw  = 1'b0;
        r.mw   = 1'b0;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] want);
        if (got !== want) begin
            n_err++;
            $display("FAIL v%0d %s: got %0h, want %0h", idx, nm, got, want);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge CLK);
        RESET         = v.rst;
        Set_XIX4      = v.sx;
        Set_XIY4      = v.sy;
        Ld_Source     = v.ld;
        Dt_in         = v.dt;
        PR_Reset_XPT  = v.pr;
        P2_Reset_XIX4 = v.p2x;
        P2_Reset_XIY4 = v.p2y;
        P2_Set_CM1    = v.scm1;
        M1_ack        = v.ack;
        PC_R1         = v.pcr;
        PC_W1         = v.pcw;
        mem_wait      = v.mw;
        #1;
        chk("stall", n_vec, {7'd0, stall}, {7'd0, v.e_stall});
        @(posedge CLK);
        #1;
        chk("XPT",        n_vec, {4'd0, XPT},    {4'd0, v.e_xpt});
        chk("notXPT",     n_vec, {4'd0, notXPT}, {4'd0, ~v.e_xpt});
        chk("Source",     n_vec, Source,         v.e_src);
        chk("notSource",  n_vec, notSource,      ~v.e_src);
        chk("not_enable", n_vec, {7'd0, not_enable}, {7'd0, v.e_ne});
        chk("is_Y",       n_vec, {7'd0, is_Y},   {7'd0, v.e_isy});
        chk("CM1",        n_vec, {7'd0, CM1},    {7'd0, v.e_cm1});
        chk("seq_err",    n_vec, {7'd0, seq_err}, {7'd0, v.e_err});
        n_vec++;
    endtask

    task automatic push();
        vq.push_back(w);
        w = clr_in(w);
    endtask

    task automatic go();
        apply(w);
        w = clr_in(w);
    endtask

    initial begin
        // ---------------- vector table ----------------
        w = '0;
        w.rst = 1'b1; w.e_ne = 1'b1; push();
        push();

        // basic IX, no waits; mem_wait alone and PC_R1 alone must not stall
        w.sx = 1'b1; w.e_ne = 1'b0; w.e_xpt = 4'd0; push();
        for (int i = 1; i <= 11; i++) begin
            if (i == 3) w.mw = 1'b1;
            if (i == 4) w.pcr = 1'b1;
            w.e_xpt = i[3:0];
            push();
        end
        w.pr = 1'b1; w.p2x = 1'b1; w.e_xpt = 4'd0; w.e_ne = 1'b1; push();

        // early end (BIT) with Source capture
        w.ld = 1'b1; w.dt = 8'h46; w.e_src = 8'h46; push();
        w.sx = 1'b1; w.e_ne = 1'b0; w.e_xpt = 4'd0; push();
        for (int i = 1; i <= 8; i++) begin
            w.e_xpt = i[3:0];
            push();
        end
        w.pr = 1'b1; w.p2x = 1'b1; w.e_xpt = 4'd0; w.e_ne = 1'b1; push();
        push();

        // back-to-back: Set_* together with the end strobe
        w.sx = 1'b1; w.e_ne = 1'b0; w.e_xpt = 4'd0; push();
        for (int i = 1; i <= 3; i++) begin
            w.e_xpt = i[3:0];
            push();
        end
        w.pr = 1'b1; w.p2x = 1'b1; w.sx = 1'b1; w.e_xpt = 4'd0; push();
        w.e_xpt = 4'd1; push();
        w.pr = 1'b1; w.p2x = 1'b1; w.sy = 1'b1; w.e_xpt = 4'd0; w.e_isy = 1'b1; push();
        w.e_xpt = 4'd1; push();
        w.pr = 1'b1; w.p2y = 1'b1; w.e_xpt = 4'd0; w.e_ne = 1'b1; w.e_isy = 1'b0; push();

        // both setters together: IY wins; a Set in RUN is ignored
        w.sx = 1'b1; w.sy = 1'b1; w.e_ne = 1'b0; w.e_isy = 1'b1; w.e_xpt = 4'd0; push();
        w.sx = 1'b1; w.e_xpt = 4'd1; push();
        w.pr = 1'b1; w.p2y = 1'b1; w.e_xpt = 4'd0; w.e_ne = 1'b1; w.e_isy = 1'b0; push();

        // CM1 set / clear, set wins a tie
        w.scm1 = 1'b1; w.e_cm1 = 1'b1; push();
        w.scm1 = 1'b1; w.ack = 1'b1; push();
        w.ack = 1'b1; w.e_cm1 = 1'b0; push();

        // IY with a 3-cycle read wait at phase 6
        w.sy = 1'b1; w.e_ne = 1'b0; w.e_isy = 1'b1; w.e_xpt = 4'd0; push();
        for (int i = 1; i <= 6; i++) begin
            w.e_xpt = i[3:0];
            push();
        end
        w.pcr = 1'b1; w.mw = 1'b1; w.e_stall = 1'b1; w.e_xpt = 4'd6; push();
        w.mw = 1'b1; push();
        w.mw = 1'b1; push();
        w.e_stall = 1'b0; w.e_xpt = 4'd7; push();
        for (int i = 8; i <= 11; i++) begin
            w.e_xpt = i[3:0];
            push();
        end
        w.pr = 1'b1; w.p2y = 1'b1; w.e_xpt = 4'd0; w.e_ne = 1'b1; w.e_isy = 1'b0; push();

        for (int k = 0; k < vq.size(); k++)
            apply(vq[k]);

        // ---------------- overrun ----------------
        w.sx = 1'b1; w.e_ne = 1'b0; w.e_xpt = 4'd0; go();
        for (int i = 1; i <= 9; i++) begin
            w.e_xpt = i[3:0];
            go();
        end
        w.pcw = 1'b1; w.mw = 1'b1; w.e_stall = 1'b1; w.e_xpt = 4'd9; go();
        w.e_stall = 1'b0; w.e_xpt = 4'd10; go();
        w.e_xpt = 4'd11; go();
        w.e_xpt = 4'd0; w.e_ne = 1'b1; w.e_err = 1'b1; go();
        repeat (3) go();
        w.sx = 1'b1; w.e_ne = 1'b0; go();
        w.pr = 1'b1; w.p2x = 1'b1; w.e_ne = 1'b1; go();

        // ---------------- reset in STALL at phase 5 ----------------
        w.scm1 = 1'b1; w.e_cm1 = 1'b1; w.ld = 1'b1; w.dt = 8'h5A; w.e_src = 8'h5A; go();
        w.sy = 1'b1; w.e_ne = 1'b0; w.e_isy = 1'b1; w.e_xpt = 4'd0; go();
        for (int i = 1; i <= 5; i++) begin
            w.e_xpt = i[3:0];
            go();
        end
        w.pcr = 1'b1; w.mw = 1'b1; w.e_stall = 1'b1; w.e_xpt = 4'd5; go();
        w.mw = 1'b1; w.rst = 1'b1;
        w.e_xpt = 4'd0; w.e_src = 8'd0; w.e_ne = 1'b1; w.e_isy = 1'b0;
        w.e_cm1 = 1'b0; w.e_err = 1'b0; go();
        w.pcr = 1'b1; w.mw = 1'b1; w.e_stall = 1'b0; go();
        w.sx = 1'b1; w.e_ne = 1'b0; w.e_xpt = 4'd0; go();
        w.e_xpt = 4'd1; go();
        w.e_xpt = 4'd2; go();
        w.pr = 1'b1; w.p2x = 1'b1; w.e_xpt = 4'd0; w.e_ne = 1'b1; go();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
